instr_mem_seq: RTL and testbench

Parametrised instruction memory for the CPU, the next generation of instr_mem: configurable word width and depth, a registered single-word read port with a valid handshake, and a sequential burst-fetch mode. A burst streams consecutive instructions starting from a base address, with wrap-around and stall. A loader writes program words through a separate write port. The block sits between the program loader/testbench and the control unit's fetch stage.

---
 rtl/instr_mem_seq.sv | 151 +++++++++++++++
 tb/tb_instr_mem_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_seq.sv
// -----------------------------------------------------------------------------
// instr_mem_seq
// Parametrised instruction memory with a registered single-word read port,
// a sequential burst-fetch engine (wrap-around at DEPTH, stallable) and a
// separate loader write port. Reads see a same-edge write to the same address
// (write-first).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (clears memory and outputs)
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write word
//   rd_req      single-word read request (honoured in IDLE only)
//   rd_addr     read address, also the burst base address
//   seq_start   start a burst at rd_addr
//   seq_len     burst length in words (1..DEPTH)
//   stall       freeze an active burst
//   rd_data     registered read word
//   rd_valid    one-cycle pulse per delivered word
//   rd_addr_out address of the word on rd_data
//   busy        burst in progress (stays high through the done cycle)
//   done        one-cycle pulse with the last burst word
//   err         one-cycle pulse on an illegal request
// -----------------------------------------------------------------------------
module instr_mem_seq #(
    parameter int DATA_WIDTH = 26,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  seq_start,
    input  logic [ADDR_WIDTH:0]   seq_len,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH+1)'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_ok;
    logic                  start_ok;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_data;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_A) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // Read source: burst pointer while bursting, otherwise the request address.
    // A same-edge write to the same address is forwarded (write-first).
    always_comb begin
        wr_ok    = wr_en && in_range(wr_addr);
        start_ok = (seq_len != '0) && (seq_len <= DEPTH_L) && in_range(rd_addr);
        src_addr = (state == BURST) ? ptr : rd_addr;
        src_data = '0;
        if (wr_ok && (wr_addr == src_addr))
            src_data = wr_data;
        else if (in_range(src_addr))
            src_data = mem[src_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_addr_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= wr_en && !in_range(wr_addr);
            if (wr_ok)
                mem[wr_addr] <= wr_data;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // seq_start wins over rd_req, even when the start is rejected
                    if (seq_start) begin
                        if (start_ok) begin
                            state <= BURST;
                            busy  <= 1'b1;
                            ptr   <= rd_addr;
                            count <= seq_len;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (rd_req) begin
                        rd_valid    <= 1'b1;
                        rd_addr_out <= rd_addr;
                        rd_data     <= src_data;
                        if (!in_range(rd_addr))
                            err <= 1'b1;
                    end
                end

                BURST: begin
                    if (rd_req || seq_start)
                        err <= 1'b1;
                    if (!stall) begin
                        rd_valid    <= 1'b1;
                        rd_addr_out <= ptr;
                        rd_data     <= src_data;
                        ptr         <= wrap_inc(ptr);
                        count       <= count - ONE_L;
                        // busy stays high through the done cycle and drops
                        // on the following edge from IDLE
                        if (count == ONE_L) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_seq
// Self-checking bench for instr_mem_seq. A behavioural model (memory array plus
// burst base/length/index) predicts every output after each clock edge; one
// compare process checks all outputs on every falling edge. Directed sequences
// add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_instr_mem_seq;

    localparam int DW = 26;
    localparam int AW = 4;
    localparam int DEPTH = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          seq_start;
    logic [AW:0]   seq_len;
    logic          stall;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] rd_addr_out;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    instr_mem_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .seq_start(seq_start), .seq_len(seq_len), .stall(stall),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_addr_out(rd_addr_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m [DEPTH];
    bit            in_burst;
    int            b_base, b_len, b_k;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    bit            e_valid, e_done, e_err, e_busy;
    int            a_emit;

    function automatic logic [DW-1:0] word_at(input int a);
        if (wr_en && int'(wr_addr) == a && int'(wr_addr) < DEPTH) return wr_data;
        if (a < DEPTH) return m[a];
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
            in_burst = 0; b_base = 0; b_len = 0; b_k = 0;
            e_data = '0; e_addr = '0;
            e_valid = 0; e_done = 0; e_err = 0; e_busy = 0;
        end else begin
            e_valid = 0;
            e_done  = 0;
            e_err   = wr_en && (int'(wr_addr) >= DEPTH);
            if (!in_burst) begin
                if (seq_start) begin
                    if (seq_len >= 1 && int'(seq_len) <= DEPTH && int'(rd_addr) < DEPTH) begin
                        in_burst = 1; b_base = int'(rd_addr); b_len = int'(seq_len); b_k = 0;
                    end else begin
                        e_err = 1;
                    end
                end else if (rd_req) begin
                    e_valid = 1;
                    e_addr  = rd_addr;
                    e_data  = word_at(int'(rd_addr));
                    if (int'(rd_addr) >= DEPTH) e_err = 1;
                end
            end else begin
                if (rd_req || seq_start) e_err = 1;
                if (!stall) begin
                    a_emit  = (b_base + b_k) % DEPTH;
                    e_valid = 1;
                    e_addr  = AW'(a_emit);
                    e_data  = word_at(a_emit);
                    b_k++;
                    if (b_k == b_len) begin
                        e_done   = 1;
                        in_burst = 0;
                    end
                end
            end
            e_busy = in_burst || e_done;
            if (wr_en && int'(wr_addr) < DEPTH) m[wr_addr] = wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("rd_valid", 32'(rd_valid), 32'(e_valid));
        check("rd_data", 32'(rd_data), 32'(e_data));
        check("rd_addr_out", 32'(rd_addr_out), 32'(e_addr));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        wr_en = 0; rd_req = 0; seq_start = 0; stall = 0;
    endtask

    logic [DW-1:0] exp_d [4];
    int            exp_a [4];
    int            pulses;
    int            last_a;

    initial begin
        quiet();
        wr_addr = '0; wr_data = '0; rd_addr = '0; seq_len = '0;
        reset = 1'b1;
        #12;
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        tick();
        reset = 1'b0;

        // 1: reads after reset return zero
        for (int a = 0; a < DEPTH; a++) begin
            rd_req = 1; rd_addr = AW'(a);
            tick();
            check("t1 valid", 32'(rd_valid), 32'd1);
            check("t1 data", 32'(rd_data), 32'd0);
            check("t1 err", 32'(err), 32'd0);
        end
        quiet(); tick();

        // 2: write then read, and same-edge write-first
        wr_en = 1; wr_addr = 3; wr_data = 26'h2AAAAAA;
        tick();
        quiet(); rd_req = 1; rd_addr = 3;
        tick();
        check("t2 read", 32'(rd_data), 32'h2AAAAAA);
        wr_en = 1; wr_addr = 3; wr_data = 26'h1555555; rd_req = 1; rd_addr = 3;
        tick();
        check("t2 bypass", 32'(rd_data), 32'h1555555);
        quiet(); tick();

        // 3: wrapping burst
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i + 'h100);
            tick();
        end
        quiet();
        exp_d = '{26'h108, 26'h109, 26'h100, 26'h101};
        exp_a = '{8, 9, 0, 1};
        seq_start = 1; rd_addr = 8; seq_len = 4;
        tick();
        quiet();
        check("t3 busy", 32'(busy), 32'd1);
        check("t3 no valid", 32'(rd_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3 addr", 32'(rd_addr_out), 32'(exp_a[k]));
            check("t3 data", 32'(rd_data), 32'(exp_d[k]));
            check("t3 done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
        check("t3 busy at done", 32'(busy), 32'd1);
        tick();
        check("t3 busy falls", 32'(busy), 32'd0);

        // 4: stalled burst
        seq_start = 1; rd_addr = 0; seq_len = 5;
        tick();
        quiet();
        pulses = 0; last_a = -1;
        for (int c = 0; c < 9; c++) begin
            stall = (c == 2 || c == 3);
            tick();
            if (rd_valid) begin
                check("t4 sequence", 32'(rd_addr_out), 32'(last_a + 1));
                last_a = int'(rd_addr_out);
                pulses++;
            end
        end
        check("t4 pulses", 32'(pulses), 32'd5);
        quiet(); tick();

        // 5: illegal requests
        wr_en = 1; wr_addr = 12; wr_data = 26'h3FFFFFF;
        tick(); quiet();
        check("t5 wr err", 32'(err), 32'd1);
        rd_req = 1; rd_addr = 11;
        tick(); quiet();
        check("t5 rd err", 32'(err), 32'd1);
        check("t5 rd data", 32'(rd_data), 32'd0);
        seq_start = 1; rd_addr = 0; seq_len = 0;
        tick(); quiet();
        check("t5 len0 err", 32'(err), 32'd1);
        seq_start = 1; rd_addr = 0; seq_len = 11;
        tick(); quiet();
        check("t5 len11 err", 32'(err), 32'd1);
        check("t5 len11 busy", 32'(busy), 32'd0);
        tick();
        check("t5 err clears", 32'(err), 32'd0);

        // 6: reset in mid-burst
        seq_start = 1; rd_addr = 0; seq_len = 8;
        tick(); quiet();
        for (int k = 0; k < 3; k++) tick();
        #2 reset = 1'b1;
        #1;
        check("t6 busy async", 32'(busy), 32'd0);
        check("t6 data async", 32'(rd_data), 32'd0);
        tick();
        #3 reset = 1'b0;
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            rd_req = 1; rd_addr = AW'(a);
            tick();
            check("t6 cleared", 32'(rd_data), 32'd0);
        end
        quiet();
        wr_en = 1; wr_addr = 5; wr_data = 26'h0ABCDEF;
        tick(); quiet();
        seq_start = 1; rd_addr = 4; seq_len = 3;
        tick(); quiet();
        tick(); tick();
        check("t6 new burst", 32'(rd_data), 32'h0ABCDEF);
        tick(); tick();

        // randomized phase
        for (int c = 0; c < 600; c++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = DW'($urandom);
            rd_req    = ($urandom_range(0, 2) == 0);
            rd_addr   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(10, 15))
                                                    : AW'($urandom_range(0, 9));
            seq_start = ($urandom_range(0, 7) == 0);
            seq_len   = (AW+1)'($urandom_range(0, 12));
            stall     = ($urandom_range(0, 3) == 0);
            tick();
        end
        quiet();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
